// File: rtl/instr_fetch_pkg.sv
// Constants shared between the fetch stage and the main control decoder:
// fetch FSM encoding, instruction geometry and PC increment.
package instr_fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals; the fetch
// stage drives the master side, memory/decode/hazard logic sit on the slave side.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic [INSTR_W-1:0]  pc_out;

  logic               redirect;
  logic [INSTR_W-1:0] redirect_pc;

  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_req, imem_addr, out_valid, instr, opcode, pc_out, fetch_count,
    input  imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, instr, opcode, pc_out, fetch_count,
    output imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one outstanding word read at a time, a single output
// register toward decode, and redirect handling that drains an in-flight read.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  state_e             state, state_n;
  logic [INSTR_W-1:0] pc, pc_n;
  logic [INSTR_W-1:0] addr_q, addr_n;
  logic [INSTR_W-1:0] instr_q, pc_out_q;
  logic               req_q, req_n;
  logic               valid_q, valid_n;
  logic               load;
  logic [CNT_W-1:0]   cnt_q;

  logic               acked, handshake;
  logic [INSTR_W-1:0] target;
  logic               unused_pc_bits;

  // An ack only means something while our request is actually on the bus.
  assign acked          = req_q && bus.imem_ack;
  assign handshake      = valid_q && bus.out_ready;
  assign target         = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid_q;
    load    = 1'b0;

    unique case (state)
      S_FETCH: begin
        if (bus.redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          // A request already on the bus cannot be withdrawn; wait out its ack.
          state_n = (req_q && !acked) ? S_DRAIN : S_FETCH;
        end else if (acked) begin
          load    = 1'b1;
          pc_n    = pc + PC_STEP;
          valid_n = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          state_n = S_FETCH;
        end else if (handshake) begin
          valid_n = 1'b0;
          state_n = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (bus.redirect) pc_n = target;
        if (acked)        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase

    req_n  = (state_n != S_HOLD);
    addr_n = (req_q && !acked) ? addr_q : pc_n;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      cnt_q    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      valid_q <= valid_n;
      if (load) begin
        instr_q  <= bus.imem_rdata;
        pc_out_q <= pc;
      end
      // A handshake coinciding with a redirect still delivered its instruction.
      if (handshake) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.out_valid   = valid_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.pc_out      = pc_out_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: wait-state memory model, scoreboard of
// expected {instr, pc} pairs, and a monitor that checks every decode handshake.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  int   mem_wait;
  int   wait_cnt;
  logic drop_pending;
  exp_t sb[$];

  logic [31:0] held_instr;

  instr_fetch_if #(.CNT_W(CNT_W)) bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Memory: acks after mem_wait cycles of a held request, data valid with ack.
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= mem_wait);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= 0;
      drop_pending <= 1'b0;
      sb.delete();
    end else if (bus.imem_req && bus.imem_ack) begin
      // A redirect on the ack cycle, or one seen while waiting, discards the data.
      if (!drop_pending && !bus.redirect)
        sb.push_back('{instr: bus.imem_rdata, pc: bus.imem_addr});
      drop_pending <= 1'b0;
      wait_cnt     <= 0;
    end else if (bus.imem_req) begin
      wait_cnt <= wait_cnt + 1;
      if (bus.redirect) drop_pending <= 1'b1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", bus.instr, e.instr);
        check("sb_pc", bus.pc_out, e.pc);
        check("sb_opcode", 32'(bus.opcode), 32'(e.instr[31:26]));
      end
    end
  end

  initial begin
    rst_n           = 1'b1;
    mem_wait        = 0;
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Asynchronous reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    check("rst_pc_out", bus.pc_out, 32'h0);
    check("rst_count", 32'(bus.fetch_count), 32'd0);
    #7 rst_n = 1'b1;

    // 0-wait fetch of addr 0.
    tick();
    check("c1_req", 32'(bus.imem_req), 32'd1);
    check("c1_addr", bus.imem_addr, 32'h0);
    tick();
    check("c2_valid", 32'(bus.out_valid), 32'd1);
    check("c2_opcode", 32'(bus.opcode), 32'b100011);
    check("c2_pc_out", bus.pc_out, 32'h0);
    check("c2_instr", bus.instr, 32'h8C01_0004);
    check("c2_req", 32'(bus.imem_req), 32'd0);
    tick();
    check("c3_addr", bus.imem_addr, 32'h4);
    check("c3_req", 32'(bus.imem_req), 32'd1);
    check("c3_count", 32'(bus.fetch_count), 32'd1);

    // Decode stalls for 5 cycles in HOLD.
    bus.out_ready = 1'b0;
    tick();
    check("hold_valid0", 32'(bus.out_valid), 32'd1);
    check("hold_pc0", bus.pc_out, 32'h4);
    held_instr = bus.instr;
    check("hold_instr0", held_instr, mem_word(32'h4));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_instr", bus.instr, held_instr);
      check("hold_pc", bus.pc_out, 32'h4);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      check("hold_count", 32'(bus.fetch_count), 32'd1);
    end

    // Three wait states on addr 8: request held for four cycles.
    mem_wait      = 3;
    bus.out_ready = 1'b1;
    tick();
    check("ws_count", 32'(bus.fetch_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("ws_req", 32'(bus.imem_req), 32'd1);
      check("ws_addr", bus.imem_addr, 32'h8);
      check("ws_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    check("ws_out_valid", 32'(bus.out_valid), 32'd1);
    check("ws_pc_out", bus.pc_out, 32'h8);

    // Redirect to 0x103 while the read of addr 12 is waiting.
    tick();
    check("dr_count", 32'(bus.fetch_count), 32'd3);
    check("dr_addr0", bus.imem_addr, 32'hC);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("dr_req", 32'(bus.imem_req), 32'd1);
      check("dr_addr", bus.imem_addr, 32'hC);
      check("dr_valid", 32'(bus.out_valid), 32'd0);
      if (i < 2) tick();
    end
    mem_wait = 0;
    tick();
    check("dr_new_addr", bus.imem_addr, 32'h0000_0100);
    check("dr_new_req", 32'(bus.imem_req), 32'd1);
    check("dr_new_valid", 32'(bus.out_valid), 32'd0);
    check("dr_new_count", 32'(bus.fetch_count), 32'd3);
    tick();
    check("dr_out_pc", bus.pc_out, 32'h0000_0100);

    // Redirect on the ack cycle of addr 0x104, target 0xFFFF_FFFC.
    tick();
    check("ra_addr", bus.imem_addr, 32'h0000_0104);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    check("ra_valid", 32'(bus.out_valid), 32'd0);
    check("ra_addr_tgt", bus.imem_addr, 32'hFFFF_FFFC);
    check("ra_req", 32'(bus.imem_req), 32'd1);
    check("ra_count", 32'(bus.fetch_count), 32'd4);
    tick();
    check("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_count5", 32'(bus.fetch_count), 32'd5);

    // Free-run until fetch_count passes 2^CNT_W handshakes.
    for (int i = 0; i < 20; i++) tick();
    check("cnt_15", 32'(bus.fetch_count), 32'd15);
    tick();
    tick();
    check("cnt_wrap", 32'(bus.fetch_count), 32'd0);

    // Stop the memory; nothing left undelivered.
    mem_wait = 100;
    tick();
    tick();
    check("end_req", 32'(bus.imem_req), 32'd1);
    check("end_addr", bus.imem_addr, 32'h2C);
    check("end_valid", 32'(bus.out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
